// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port system RAM between the CPU (strobed by
// cpu_clken), the video character fetch and the ioctl download port.
// Fixed priority CPU > video > download, one access at a time, each access
// runs ISSUE -> WAIT (MEM_LATENCY-1 cycles) -> DONE.
// Optional feature: define RAM_ARB_STATS_EN to add the stall_max output.
module ram_arbiter #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic              sys_clock,
  input  logic              reset_n,
  input  logic              cpu_clken,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_dout,
  input  logic              dl_req,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [DATA_W-1:0] dl_data,
  output logic              dl_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  output logic              ram_cs,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              cpu_stall
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [7:0]        stall_max
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VID, OWN_DL} owner_t;

  localparam logic [2:0] WAIT_LOAD = 3'((MEM_LATENCY >= 2) ? (MEM_LATENCY - 2) : 0);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              pend_we_q, pend_we_d;
  logic [DATA_W-1:0] pend_din_q, pend_din_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              cur_we_q, cur_we_d;
  logic [DATA_W-1:0] cpu_dout_q, cpu_dout_d;
  logic [DATA_W-1:0] vid_dout_q, vid_dout_d;

  // Next-state: grant arbitration, latency count, result capture, CPU slot.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_we_d   = pend_we_q;
    pend_din_d  = pend_din_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    cur_we_d    = cur_we_q;
    cpu_dout_d  = cpu_dout_q;
    vid_dout_d  = vid_dout_q;
    unique case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          state_d    = S_ISSUE;
          owner_d    = OWN_CPU;
          ram_addr_d = pend_addr_q;
          ram_din_d  = pend_din_q;
          cur_we_d   = pend_we_q;
        end else if (vid_req) begin
          state_d    = S_ISSUE;
          owner_d    = OWN_VID;
          ram_addr_d = vid_addr;
          cur_we_d   = 1'b0;
        end else if (dl_req) begin
          state_d    = S_ISSUE;
          owner_d    = OWN_DL;
          ram_addr_d = dl_addr;
          ram_din_d  = dl_data;
          cur_we_d   = 1'b1;
        end else if (cpu_clken) begin
          // Bypass: the strobe is granted straight from the port while the
          // slot below still latches it, so cpu_stall covers the access.
          state_d    = S_ISSUE;
          owner_d    = OWN_CPU;
          ram_addr_d = cpu_addr;
          ram_din_d  = cpu_din;
          cur_we_d   = cpu_we;
        end
      end
      S_ISSUE: begin
        if (MEM_LATENCY <= 1) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
        unique case (owner_q)
          OWN_CPU: begin
            if (!cur_we_q) cpu_dout_d = ram_dout;
            pend_d = 1'b0;
          end
          OWN_VID: vid_dout_d = ram_dout;
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
    // A strobe in the same cycle as a CPU DONE starts a new pending access.
    if (cpu_clken) begin
      pend_d      = 1'b1;
      pend_addr_d = cpu_addr;
      pend_we_d   = cpu_we;
      pend_din_d  = cpu_din;
    end
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_we_q   <= 1'b0;
      pend_din_q  <= '0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      cur_we_q    <= 1'b0;
      cpu_dout_q  <= '0;
      vid_dout_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_we_q   <= pend_we_d;
      pend_din_q  <= pend_din_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      cur_we_q    <= cur_we_d;
      cpu_dout_q  <= cpu_dout_d;
      vid_dout_q  <= vid_dout_d;
    end
  end

  // Strobes decode from state_q so they drop as soon as reset asserts; read
  // data passes through during DONE so it is valid with the ack.
  always_comb begin
    ram_cs    = (state_q == S_ISSUE);
    ram_we    = (state_q == S_ISSUE) && cur_we_q;
    ram_addr  = ram_addr_q;
    ram_din   = ram_din_q;
    vid_ack   = (state_q == S_DONE) && (owner_q == OWN_VID);
    dl_ack    = (state_q == S_DONE) && (owner_q == OWN_DL);
    vid_dout  = vid_ack ? ram_dout : vid_dout_q;
    cpu_dout  = ((state_q == S_DONE) && (owner_q == OWN_CPU) && !cur_we_q) ? ram_dout : cpu_dout_q;
    cpu_stall = pend_q;
  end

`ifdef RAM_ARB_STATS_EN
  logic [7:0] run_q, run_d;
  logic [7:0] stall_max_q, stall_max_d;

  // Current stall run length and the longest run since reset, both saturating.
  always_comb begin
    run_d       = '0;
    stall_max_d = stall_max_q;
    if (pend_q) begin
      run_d = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
      if (run_d > stall_max_q) stall_max_d = run_d;
    end
  end

  // Statistics registers.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      run_q       <= '0;
      stall_max_q <= '0;
    end else begin
      run_q       <= run_d;
      stall_max_q <= stall_max_d;
    end
  end

  assign stall_max = stall_max_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM and scoreboard queues.
// Define RAM_ARB_STATS_EN for both files to cover the stall_max output.
module tb_ram_arbiter;
  localparam int unsigned MEM_LATENCY = 2;
  localparam int unsigned STALL_BOUND = 2 * (MEM_LATENCY + 2);

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_clken;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        vid_req;
  logic [15:0] vid_addr;
  logic        vid_ack;
  logic [7:0]  vid_dout;
  logic        dl_req;
  logic [15:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_ack;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic        ram_cs;
  logic [7:0]  ram_dout;
  logic        cpu_stall;
`ifdef RAM_ARB_STATS_EN
  logic [7:0]  stall_max;
`endif

  int checks   = 0;
  int failures = 0;

  // scoreboards
  logic [7:0]  cpu_q [$];
  logic [7:0]  vid_q [$];
  logic [23:0] wr_q  [$];

  // monitor state
  int  run = 0, last_run = 0, max_run = 0;
  int  vid_acks = 0, dl_acks = 0;
  time vid_t = 0, dl_t = 0;
  logic prev_stall = 1'b0;

  // behavioural RAM
  logic [7:0]  mem [0:65535];
  logic [7:0]  rpipe [MEM_LATENCY];
  logic        pre_en = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(16), .DATA_W(8), .MEM_LATENCY(MEM_LATENCY)) dut (
    .sys_clock(clk), .reset_n(reset_n),
    .cpu_clken(cpu_clken), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_dout(vid_dout),
    .dl_req(dl_req), .dl_addr(dl_addr), .dl_data(dl_data), .dl_ack(dl_ack),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_cs(ram_cs),
    .ram_dout(ram_dout), .cpu_stall(cpu_stall)
`ifdef RAM_ARB_STATS_EN
    , .stall_max(stall_max)
`endif
  );

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (ram_cs && ram_we) mem[ram_addr] <= ram_din;
    rpipe[0] <= (ram_cs && !ram_we) ? mem[ram_addr] : 8'hxx;
    for (int i = 1; i < MEM_LATENCY; i++) rpipe[i] <= rpipe[i-1];
  end
  assign ram_dout = rpipe[MEM_LATENCY-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_access(input logic [15:0] a, input logic we, input logic [7:0] d,
                            input logic [7:0] exp_dout);
    cpu_addr = a; cpu_we = we; cpu_din = d; cpu_clken = 1'b1;
    cpu_q.push_back(exp_dout);
    if (we) wr_q.push_back({a, d});
    cyc();
    cpu_clken = 1'b0;
  endtask

  task automatic wait_cpu_done(input string tag);
    logic ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!cpu_stall) begin ok = 1'b1; break; end
    end
    #1;
    chk(tag, ok, 1'b1);
  endtask

  task automatic wait_vid_ack(input string tag);
    logic ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (vid_ack) begin ok = 1'b1; break; end
    end
    vid_req = 1'b0;
    #1;
    chk(tag, ok, 1'b1);
  endtask

  task automatic wait_dl_ack(input string tag);
    logic ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dl_ack) begin ok = 1'b1; break; end
    end
    dl_req = 1'b0;
    #1;
    chk(tag, ok, 1'b1);
  endtask

  // DL write granted, then a CPU read strobed one cycle after the grant.
  task automatic dl_then_cpu(input logic [15:0] da, input logic [7:0] dd,
                             input logic [15:0] ca, input logic [7:0] exp_dout);
    int dl0;
    dl0 = dl_acks;
    dl_addr = da; dl_data = dd; dl_req = 1'b1;
    wr_q.push_back({da, dd});
    cyc();
    cpu_addr = ca; cpu_we = 1'b0; cpu_clken = 1'b1;
    cpu_q.push_back(exp_dout);
    @(negedge clk);
    chk("t2_dl_issue_cs", ram_cs, 1'b1);
    cyc();
    cpu_clken = 1'b0;
    wait_dl_ack("t2_dl_ack_seen");
    wait_cpu_done("t2_cpu_done");
    chk("t2_dl_ack_count", dl_acks - dl0, 1);
    chk("t2_stall_bound", last_run <= STALL_BOUND, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cs"}, ram_cs, 1'b0);
    chk({tag, "_we"}, ram_we, 1'b0);
    chk({tag, "_acks"}, {vid_ack, dl_ack}, 2'b00);
    chk({tag, "_stall"}, cpu_stall, 1'b0);
    chk({tag, "_douts"}, {cpu_dout, vid_dout}, 16'h0000);
    chk({tag, "_ram_addr_din"}, {ram_addr, ram_din}, 24'h000000);
  endtask

  initial begin
    reset_n = 1'b0; cpu_clken = 1'b0; cpu_addr = '0; cpu_we = 1'b0; cpu_din = '0;
    vid_req = 1'b0; vid_addr = '0; dl_req = 1'b0; dl_addr = '0; dl_data = '0;

    fork
      forever begin
        @(negedge clk);
        if (!reset_n) begin
          run = 0; max_run = 0; prev_stall = 1'b0;
        end else begin
          if (cpu_clken) chk("clken_overlap", cpu_stall, 1'b0);
          if (cpu_stall) run++;
          else if (run > 0) begin
            last_run = run;
            if (run > max_run) max_run = run;
            run = 0;
          end
          if (prev_stall && !cpu_stall) begin
            chk("cpu_q_nonempty", cpu_q.size() != 0, 1'b1);
            if (cpu_q.size() != 0) chk("cpu_dout", cpu_dout, cpu_q.pop_front());
          end
          prev_stall = cpu_stall;
          if (ram_cs && ram_we) begin
            chk("wr_q_nonempty", wr_q.size() != 0, 1'b1);
            if (wr_q.size() != 0) chk("ram_write_addr_data", {ram_addr, ram_din}, wr_q.pop_front());
          end
        end
        if (vid_ack) begin
          vid_acks++; vid_t = $time;
          chk("vid_q_nonempty", vid_q.size() != 0, 1'b1);
          if (vid_q.size() != 0) chk("vid_dout", vid_dout, vid_q.pop_front());
        end
        if (dl_ack) begin
          dl_acks++; dl_t = $time;
        end
      end
    join_none

    // reset state and RAM preload
    pre_addr = 16'h0300; pre_data = 8'hA5; pre_en = 1'b1;
    cyc();
    pre_en = 1'b0;
    check_all_zero("reset");
    cyc();
    reset_n = 1'b1;
    cyc(); cyc();

    // 1: lone CPU read takes the bypass path
    cpu_access(16'h0300, 1'b0, 8'h00, 8'hA5);
    @(negedge clk);
    chk("t1_cs_next_cycle", ram_cs, 1'b1);
    chk("t1_ram_addr", ram_addr, 16'h0300);
    chk("t1_ram_we", ram_we, 1'b0);
    chk("t1_stall", cpu_stall, 1'b1);
    wait_cpu_done("t1_cpu_done");
    chk("t1_stall_len", last_run, MEM_LATENCY + 1);
    cyc();

    // 2: download write, CPU read queued behind it
    dl_then_cpu(16'h0280, 8'h3C, 16'h0300, 8'hA5);
    cyc();

    // 3: video and download together, video first
    begin
      int v0, d0;
      v0 = vid_acks; d0 = dl_acks;
      vid_addr = 16'h0280; vid_req = 1'b1;
      vid_q.push_back(8'h3C);
      dl_addr = 16'h0281; dl_data = 8'h77; dl_req = 1'b1;
      wr_q.push_back({16'h0281, 8'h77});
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (vid_ack) vid_req = 1'b0;
        if (dl_ack) dl_req = 1'b0;
        if (!vid_req && !dl_req) break;
      end
      repeat (4) cyc();
      chk("t3_reqs_served", {vid_req, dl_req}, 2'b00);
      chk("t3_vid_ack_count", vid_acks - v0, 1);
      chk("t3_dl_ack_count", dl_acks - d0, 1);
      chk("t3_vid_before_dl", vid_t < dl_t, 1'b1);
    end

    // 4: CPU write, then video reads it back; cpu_dout keeps the old read
    cpu_access(16'h0300, 1'b1, 8'h5A, 8'hA5);
    wait_cpu_done("t4_cpu_done");
    vid_addr = 16'h0300; vid_req = 1'b1;
    vid_q.push_back(8'h5A);
    wait_vid_ack("t4_vid_ack_seen");
    chk("t4_cpu_dout_held", cpu_dout, 8'hA5);
    cyc();

    // 5: reset during the WAIT of a video access
    begin
      int v0;
      v0 = vid_acks;
      vid_addr = 16'h0281; vid_req = 1'b1;
      cyc();
      cyc();
      @(negedge clk);
      chk("t5_in_wait", {ram_cs, vid_ack}, 2'b00);
      #1 reset_n = 1'b0;
      vid_req = 1'b0;
      #1;
      check_all_zero("t5_async");
      cyc(); cyc();
      reset_n = 1'b1;
      cyc();
      chk("t5_no_ack", vid_acks - v0, 0);
      vid_req = 1'b1;
      vid_q.push_back(8'h77);
      wait_vid_ack("t5_vid_after_reset");
      chk("t5_ack_count", vid_acks - v0, 1);
    end
    cyc();

    // 6: scenario 2 again after reset; stall statistics follow the longest run
    dl_then_cpu(16'h0282, 8'hC3, 16'h0281, 8'h77);
`ifdef RAM_ARB_STATS_EN
    chk("t6_stall_max", stall_max, max_run);
`endif
    cyc(); cyc();
    chk("sb_empty", cpu_q.size() + vid_q.size() + wr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
